// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
// ST_FAULT exists only when IFU_MISALIGN_CHECK_EN is defined.
package ifu_pkg;

   localparam logic [31:0] IFU_RESET_VECTOR = 32'h8000_0000;
   localparam logic [31:0] RV_NOP           = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_REQ   = 3'd0,
      ST_WAIT  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_DRAIN = 3'd3
`ifdef IFU_MISALIGN_CHECK_EN
      ,
      ST_FAULT = 3'd4
`endif
   } fetch_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// rtl/ifu_pc_reg.sv - fetch PC register with reset/handoff/flush load muxing
// IFU_MISALIGN_CHECK_EN keeps raw targets and flags misalignment; otherwise loads are word-aligned.
module ifu_pc_reg
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFU_RESET_VECTOR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_handoff,
   input  logic        load_flush,
   input  logic [31:0] next_pc,
   input  logic [31:0] flush_pc,
   output logic [31:0] pc
`ifdef IFU_MISALIGN_CHECK_EN
   ,
   output logic        target_bad
`endif
);

   logic [31:0] target;
   logic        load;

   // flush wins over a simultaneous handoff
   assign target = load_flush ? flush_pc : next_pc;
   assign load   = load_flush | load_handoff;

`ifdef IFU_MISALIGN_CHECK_EN
   assign target_bad = (target[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC;
      else if (load)
         pc <= target;
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC;
      else if (load)
         pc <= target & 32'hFFFF_FFFC;
   end
`endif

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - rv32e instruction fetch stage, one outstanding imem read
// Optional IFU_MISALIGN_CHECK_EN adds the misalign output and the FAULT state.
module inst_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = IFU_RESET_VECTOR
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        imem_resp_ready,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] pc_o,
   input  logic [31:0] next_pc,
   input  logic        flush,
   input  logic [31:0] flush_pc
`ifdef IFU_MISALIGN_CHECK_EN
   ,
   output logic        misalign
`endif
);

   fetch_state_e state, state_nxt, restart, drain_exit;
   logic         run;
   logic [31:0]  pc;
   logic [31:0]  instr_q;
   logic         handoff;
   logic         capture;
   logic         req_fire;
`ifdef IFU_MISALIGN_CHECK_EN
   logic         target_bad;
`endif

   ifu_pc_reg #(.RESET_PC(RESET_VECTOR)) u_pc_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_handoff (handoff),
      .load_flush   (flush),
      .next_pc      (next_pc),
      .flush_pc     (flush_pc),
      .pc           (pc)
`ifdef IFU_MISALIGN_CHECK_EN
      ,
      .target_bad   (target_bad)
`endif
   );

   // run keeps the request low while reset is held, even though state already reads REQ
   assign imem_req_valid  = run && (state == ST_REQ);
   assign imem_resp_ready = (state == ST_WAIT) || (state == ST_DRAIN);
   assign instr_valid     = (state == ST_HOLD);
   assign imem_req_addr   = pc;
   assign pc_o            = pc;
   assign instr           = instr_q;
`ifdef IFU_MISALIGN_CHECK_EN
   assign misalign        = (state == ST_FAULT);
`endif

   assign req_fire = imem_req_valid && imem_req_ready;
   assign handoff  = instr_valid && instr_ready && !flush;
   assign capture  = (state == ST_WAIT) && imem_resp_valid && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_REQ;
         run   <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instr_q <= RV_NOP;
      else if (capture)
         instr_q <= imem_resp_data;
   end

   always_comb begin
      restart    = ST_REQ;
      drain_exit = ST_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
      if (target_bad)
         restart = ST_FAULT;
      if (pc[1:0] != 2'b00)
         drain_exit = ST_FAULT;
`endif
      state_nxt = state;
      case (state)
         ST_REQ: begin
            if (flush)
               state_nxt = req_fire ? ST_DRAIN : restart;
            else if (req_fire)
               state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (flush)
               state_nxt = imem_resp_valid ? restart : ST_DRAIN;
            else if (imem_resp_valid)
               state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (flush || instr_ready)
               state_nxt = restart;
         end
         ST_DRAIN: begin
            // a flush coinciding with the stale response still retires it
            if (imem_resp_valid)
               state_nxt = flush ? restart : drain_exit;
         end
`ifdef IFU_MISALIGN_CHECK_EN
         ST_FAULT: begin
            if (flush)
               state_nxt = restart;
         end
`endif
         default: state_nxt = ST_REQ;
      endcase
   end

endmodule
